// File: rtl/scp_ingress_arb.sv
// rtl/scp_ingress_arb.sv - round-robin packet arbiter feeding the SCP link
// Grants one requester per packet, forwards its bytes with one cycle latency, aborts stalled packets.
module scp_ingress_arb #(
   parameter int NREQ    = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 255
) (
   input  logic              Clk,
   input  logic              ARstb,
   input  logic [NREQ-1:0]   ReqValid,
   input  logic [8*NREQ-1:0] ReqData,
   input  logic [NREQ-1:0]   ReqLast,
   output logic [NREQ-1:0]   ReqReady,
   output logic              EValid,
   output logic [7:0]        ED,
   output logic [NREQ-1:0]   Grant,
   output logic              Busy,
   output logic              TimeoutErr,
   output logic [7:0]        ErrCount
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      SPACE  = 2'd2
   } state_t;

   localparam state_t END_STATE = (GAP == 0) ? IDLE : SPACE;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            arm_q, arm_d;
   logic [7:0]      stall_q, stall_d;
   logic [3:0]      gap_q, gap_d;
   logic            evalid_q, evalid_d;
   logic [7:0]      ed_q, ed_d;
   logic            terr_q, terr_d;
   logic [7:0]      errcnt_q, errcnt_d;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   cand;
   logic            sel_valid;
   logic            sel_last;
   logic [7:0]      sel_data;
   logic            xfer;

   // Search starts one past the last granted index so every requester gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NREQ);
         if (!win_found && ReqValid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_valid = |(ReqValid & grant_q);
      sel_last  = |(ReqValid & ReqLast & grant_q);
      sel_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            sel_data = ReqData[8*i +: 8];
         end
      end
   end

   assign xfer = (state_q == STREAM) && sel_valid;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      arm_d    = 1'b1;
      stall_d  = stall_q;
      gap_d    = gap_q;
      evalid_d = 1'b0;
      ed_d     = 8'h00;
      terr_d   = 1'b0;
      errcnt_d = errcnt_q;
      case (state_q)
         IDLE: begin
            // arm_q keeps the first edge after reset release grant-free.
            if (arm_q && win_found) begin
               state_d          = STREAM;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               ptr_d            = win_idx;
               stall_d          = 8'd0;
            end
         end
         STREAM: begin
            if (xfer) begin
               evalid_d = 1'b1;
               ed_d     = sel_data;
               stall_d  = 8'd0;
               if (sel_last) begin
                  state_d = END_STATE;
                  grant_d = '0;
                  gap_d   = 4'd0;
               end
            end else if (stall_q == 8'(TIMEOUT)) begin
               terr_d   = 1'b1;
               errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
               state_d  = END_STATE;
               grant_d  = '0;
               gap_d    = 4'd0;
               stall_d  = 8'd0;
            end else begin
               stall_d = stall_q + 8'd1;
            end
         end
         SPACE: begin
            if (gap_q == 4'(GAP - 1)) begin
               state_d = IDLE;
               gap_d   = 4'd0;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge ARstb) begin
      if (!ARstb) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         ptr_q    <= PW'(NREQ - 1);
         arm_q    <= 1'b0;
         stall_q  <= 8'd0;
         gap_q    <= 4'd0;
         evalid_q <= 1'b0;
         ed_q     <= 8'h00;
         terr_q   <= 1'b0;
         errcnt_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         arm_q    <= arm_d;
         stall_q  <= stall_d;
         gap_q    <= gap_d;
         evalid_q <= evalid_d;
         ed_q     <= ed_d;
         terr_q   <= terr_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign ReqReady   = (state_q == STREAM) ? grant_q : '0;
   assign Grant      = grant_q;
   assign Busy       = (state_q != IDLE);
   assign EValid     = evalid_q;
   assign ED         = ed_q;
   assign TimeoutErr = terr_q;
   assign ErrCount   = errcnt_q;

endmodule

// File: tb/tb_scp_ingress_arb.sv
// tb/tb_scp_ingress_arb.sv - self-checking bench for scp_ingress_arb
// Packet-level reference model plus directed scenarios with literal expectations.
module tb_scp_ingress_arb;

   localparam int N  = 4;
   localparam int G  = 2;
   localparam int TO = 4;

   logic           Clk;
   logic           ARstb;
   logic [N-1:0]   ReqValid;
   logic [8*N-1:0] ReqData;
   logic [N-1:0]   ReqLast;
   logic [N-1:0]   ReqReady;
   logic           EValid;
   logic [7:0]     ED;
   logic [N-1:0]   Grant;
   logic           Busy;
   logic           TimeoutErr;
   logic [7:0]     ErrCount;

   int n_vec = 0;
   int n_err = 0;

   scp_ingress_arb #(.NREQ(N), .GAP(G), .TIMEOUT(TO)) dut (
      .Clk        (Clk),
      .ARstb      (ARstb),
      .ReqValid   (ReqValid),
      .ReqData    (ReqData),
      .ReqLast    (ReqLast),
      .ReqReady   (ReqReady),
      .EValid     (EValid),
      .ED         (ED),
      .Grant      (Grant),
      .Busy       (Busy),
      .TimeoutErr (TimeoutErr),
      .ErrCount   (ErrCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: phase 0 idle, 1 owner streaming, 2 link spacing.
   int         m_phase = 0;
   int         m_owner = -1;
   int         m_last  = -1;
   int         m_stall = 0;
   int         m_left  = 0;
   int         m_errs  = 0;
   bit         m_armed = 0;
   bit         m_ev    = 0;
   bit         m_terr  = 0;
   logic [7:0] m_ed    = 8'h00;
   bit         m_live  = 0;

   initial begin
      forever begin
         @(posedge Clk or negedge ARstb);
         if (ARstb !== 1'b1) begin
            m_phase = 0; m_owner = -1; m_last = -1; m_stall = 0; m_left = 0;
            m_errs = 0; m_armed = 0; m_ev = 0; m_terr = 0; m_ed = 8'h00; m_live = 1;
         end else begin
            bit         was_armed;
            bit         ended;
            bit         ov;
            bit         ol;
            logic [7:0] od;
            was_armed = m_armed;
            m_armed   = 1;
            m_ev      = 0;
            m_ed      = 8'h00;
            m_terr    = 0;
            ended     = 0;
            ov = 0; ol = 0; od = 8'h00;
            for (int i = 0; i < N; i++) begin
               if (i == m_owner) begin
                  ov = ReqValid[i];
                  ol = ReqLast[i];
                  od = ReqData[8*i +: 8];
               end
            end
            if (m_phase == 0) begin
               if (was_armed && ReqValid != '0) begin
                  for (int k = 1; k <= N; k++) begin
                     int c;
                     c = (m_last + k + N) % N;
                     if (m_owner < 0 && ReqValid[c]) m_owner = c;
                  end
                  m_last  = m_owner;
                  m_stall = 0;
                  m_phase = 1;
               end
            end else if (m_phase == 1) begin
               if (ov) begin
                  m_ev    = 1;
                  m_ed    = od;
                  m_stall = 0;
                  ended   = ol;
               end else if (m_stall == TO) begin
                  m_terr = 1;
                  if (m_errs < 255) m_errs++;
                  ended = 1;
               end else begin
                  m_stall++;
               end
               if (ended) begin
                  m_owner = -1;
                  m_stall = 0;
                  if (G > 0) begin
                     m_phase = 2;
                     m_left  = G;
                  end else begin
                     m_phase = 0;
                  end
               end
            end else begin
               m_left--;
               if (m_left == 0) m_phase = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         if (m_live) begin
            logic [N-1:0] eg;
            logic [26:0]  ev;
            logic [26:0]  av;
            eg = '0;
            for (int i = 0; i < N; i++) if (i == m_owner) eg[i] = 1'b1;
            ev = {m_ev, m_ed, eg, (m_phase == 1) ? eg : {N{1'b0}}, (m_phase != 0), m_terr, 8'(m_errs)};
            av = {EValid, ED, Grant, ReqReady, Busy, TimeoutErr, ErrCount};
            n_vec++;
            if (av !== ev) begin
               n_err++;
               $display("FAIL cycle_cmp t=%0t actual=%h required=%h (EValid,ED,Grant,ReqReady,Busy,TimeoutErr,ErrCount)",
                        $time, av, ev);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #2;
   endtask

   task automatic at_neg();
      @(negedge Clk);
   endtask

   task automatic reset_dut();
      ARstb    = 1'b0;
      ReqValid = '0;
      ReqLast  = '0;
      ReqData  = '0;
      step();
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int cyc;
      int got_d[$];
      int got_c[$];

      ARstb = 1'b0; ReqValid = '0; ReqLast = '0; ReqData = '0;

      // Three-byte packet from requester 0.
      reset_dut();
      at_neg();
      chk("rst_evalid", EValid, 0);
      chk("rst_grant", Grant, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_errcnt", ErrCount, 0);
      step();
      ARstb = 1'b1; ReqValid = 4'b0001; ReqData = 32'h0000_00A1; ReqLast = '0;
      step(); at_neg();
      chk("no_early_grant", Grant, 0);
      step(); at_neg();
      chk("t1_grant", Grant, 4'b0001);
      chk("t1_ready", ReqReady, 4'b0001);
      step(); ReqData = 32'h0000_00A2;
      at_neg(); chk("t1_byte1", {EValid, ED}, {1'b1, 8'hA1});
      step(); ReqData = 32'h0000_00A3; ReqLast = 4'b0001;
      at_neg(); chk("t1_byte2", {EValid, ED}, {1'b1, 8'hA2});
      step(); ReqValid = '0; ReqLast = '0;
      at_neg(); chk("t1_byte3", {EValid, ED}, {1'b1, 8'hA3});
      chk("t1_busy_space", Busy, 1);
      step(); at_neg();
      chk("t1_ev_off", EValid, 0);
      step(); at_neg();
      chk("t1_busy_low", Busy, 0);

      // All four hold single-byte packets: rotation and link spacing.
      reset_dut();
      ARstb = 1'b1; ReqValid = '1; ReqLast = '1; ReqData = 32'h1312_1110;
      cyc = 0;
      for (int k = 0; k < 40 && got_d.size() < 5; k++) begin
         step(); at_neg();
         cyc++;
         if (EValid) begin
            got_d.push_back(int'(ED));
            got_c.push_back(cyc);
         end
      end
      ReqValid = '0; ReqLast = '0;
      chk("t2_count", got_d.size(), 5);
      if (got_c.size() > 0) chk("t2_first_cycle", got_c[0], 3);
      for (int i = 0; i < got_d.size(); i++) chk("t2_order", got_d[i], 32'h10 + (i % 4));
      for (int i = 1; i < got_c.size(); i++) chk("t2_spacing", got_c[i] - got_c[i-1], G + 2);

      // Requester 2 stalls after one byte and gets aborted.
      reset_dut();
      ARstb = 1'b1; ReqValid = 4'b0100; ReqData = 32'h0055_0000; ReqLast = '0;
      step(); at_neg();
      step(); at_neg();
      chk("t3_grant", Grant, 4'b0100);
      step(); ReqValid = 4'b1001; ReqLast = 4'b1001; ReqData = 32'h6600_0077;
      at_neg(); chk("t3_byte", {EValid, ED}, {1'b1, 8'h55});
      for (int k = 0; k < 4; k++) begin
         step(); at_neg();
         chk("t3_quiet", {TimeoutErr, EValid}, 0);
      end
      step(); at_neg();
      chk("t3_terr", TimeoutErr, 1);
      chk("t3_errcnt", ErrCount, 1);
      chk("t3_model_errs", m_errs, 1);
      step(); at_neg();
      chk("t3_terr_pulse", TimeoutErr, 0);
      step(); step(); at_neg();
      chk("t3_next_grant", Grant, 4'b1000);
      chk("t3_model_owner", m_owner, 3);
      step(); ReqValid = '0; ReqLast = '0;
      at_neg(); chk("t3_req3_byte", {EValid, ED}, {1'b1, 8'h66});

      // Repeated aborts until the error counter saturates.
      reset_dut();
      ARstb = 1'b1;
      for (int i = 1; i <= 257; i++) begin
         ReqValid = 4'b0001;
         ok = 0;
         for (int k = 0; k < 20 && !ok; k++) begin
            step();
            if (Grant[0]) ok = 1;
         end
         ReqValid = '0;
         chk("t4_grant_seen", ok, 1);
         if (!ok) break;
         ok = 0;
         for (int k = 0; k < 20 && !ok; k++) begin
            step();
            if (TimeoutErr) ok = 1;
         end
         chk("t4_abort_seen", ok, 1);
         if (!ok) break;
         if (i == 3)   chk("t4_cnt3", ErrCount, 3);
         if (i == 255) chk("t4_cnt255", ErrCount, 8'hFF);
      end
      chk("t4_saturated", ErrCount, 8'hFF);

      // Reset in the middle of a five-byte packet from requester 1.
      reset_dut();
      ARstb = 1'b1; ReqValid = 4'b0010; ReqData = 32'h0000_B100; ReqLast = '0;
      step(); step(); at_neg();
      chk("t5_grant", Grant, 4'b0010);
      step(); ReqData = 32'h0000_B200;
      step(); ReqData = 32'h0000_B300;
      at_neg(); chk("t5_byte2", {EValid, ED}, {1'b1, 8'hB2});
      #1 ARstb = 1'b0;
      #1 chk("t5_rst_outs", {EValid, ED, Grant, ReqReady, Busy, TimeoutErr, ErrCount}, 0);
      ReqValid = 4'b0011; ReqLast = 4'b0011; ReqData = 32'h0000_C2C1;
      step(); step();
      ARstb = 1'b1;
      step(); at_neg();
      chk("t5_no_early_grant", Grant, 0);
      step(); at_neg();
      chk("t5_req0_first", Grant, 4'b0001);
      step(); ReqValid = '0; ReqLast = '0;
      at_neg(); chk("t5_req0_byte", {EValid, ED}, {1'b1, 8'hC1});
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
